// File: rtl/slave_fifo_pkg.sv
// Shared types and constants for the multi-channel FX2 slave FIFO writer.
// Header word layout: {tag[7:0], 4'b0, channel[3:0]}.
package slave_fifo_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_DATA,
    S_COMMIT,
    S_GAP
  } state_e;

  localparam int HDR_TAG_LSB = 8;
  localparam int CH_FIELD_W = 4;

  localparam logic STROBE_ON = 1'b0;
  localparam logic STROBE_OFF = 1'b1;

  function automatic logic [15:0] hdr_word(
    input logic [7:0] tag,
    input logic [CH_FIELD_W-1:0] ch
  );
    hdr_word = {tag, {(HDR_TAG_LSB - CH_FIELD_W){1'b0}}, ch};
  endfunction

endpackage

// File: rtl/slave_fifo_mux_writer_rr_arbiter.sv
// Combinational round-robin pick: lowest requester at or above ptr, wrapping.
// The pointer register is owned by the parent.
module rr_arbiter #(
  parameter int NUM_CH = 4
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [3:0]        ptr,
  output logic [NUM_CH-1:0] gnt,
  output logic [3:0]        idx,
  output logic              any
);

  localparam int IW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [IW-1:0] c;

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    c = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      c = IW'((int'(ptr) + i) % NUM_CH);
      if (!any && req[c]) begin
        any = 1'b1;
        gnt[c] = 1'b1;
        idx = 4'(c);
      end
    end
  end

endmodule

// File: rtl/slave_fifo_mux_writer.sv
// Round-robin merge of NUM_CH word streams into the FX2 slave FIFO,
// one tagged packet run (header + payload + optional PKTEND) per grant.
module slave_fifo_mux_writer
  import slave_fifo_pkg::*;
#(
  parameter int         NUM_CH    = 4,
  parameter int         PKT_WORDS = 256,
  parameter logic [1:0] EP_ADDR   = 2'b10,
  parameter logic [7:0] HDR_TAG   = 8'hA5
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [NUM_CH-1:0]      CH_VALID,
  input  logic [16*NUM_CH-1:0]   CH_DATA,
  input  logic [NUM_CH-1:0]      CH_LAST,
  output logic [NUM_CH-1:0]      CH_READY,
  input  logic                   FLAG_FULL,
  output logic [15:0]            FD_OUT,
  output logic                   FD_OE,
  output logic                   SLWR,
  output logic                   PKTEND,
  output logic                   SLOE,
  output logic                   SLRD,
  output logic [1:0]             FIFOADR,
  output logic [3:0]             BUSY_CH,
  output logic                   GRANT_ACT
);

  localparam int CW = $clog2(PKT_WORDS);

  state_e state, state_nx;

  logic [3:0]        ptr;
  logic [3:0]        busy;
  logic [NUM_CH-1:0] gnt_q;
  logic [CW-1:0]     cnt;

  logic [NUM_CH-1:0] gnt;
  logic [3:0]        gidx;
  logic              gany;

  logic [15:0] ch_word;
  logic        ch_valid;
  logic        ch_last;
  logic        ready;
  logic        wr_en;
  logic [15:0] wr_word;
  logic        pkt_fire;

  rr_arbiter #(
    .NUM_CH(NUM_CH)
  ) u_arb (
    .req(CH_VALID),
    .ptr(ptr),
    .gnt(gnt),
    .idx(gidx),
    .any(gany)
  );

  always_comb begin
    ch_word = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (gnt_q[i]) ch_word = CH_DATA[16*i +: 16];
    end
  end

  assign ch_valid = |(CH_VALID & gnt_q);
  assign ch_last  = |(CH_LAST & gnt_q);
  assign ready    = (state == S_DATA) && FLAG_FULL;
  assign CH_READY = gnt_q & {NUM_CH{ready}};

  always_comb begin
    state_nx = state;
    wr_en = 1'b0;
    wr_word = hdr_word(HDR_TAG, busy);
    pkt_fire = 1'b0;
    unique case (state)
      S_IDLE: if (gany) state_nx = S_HDR;
      S_HDR: begin
        if (FLAG_FULL) begin
          wr_en = 1'b1;
          state_nx = S_DATA;
        end
      end
      S_DATA: begin
        wr_word = ch_word;
        if (ready && ch_valid) begin
          wr_en = 1'b1;
          if (ch_last) state_nx = S_COMMIT;
        end
      end
      // a zero count means the FX2 already committed a full packet
      S_COMMIT: begin
        pkt_fire = (cnt != '0);
        state_nx = S_GAP;
      end
      S_GAP: state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= S_IDLE;
      ptr    <= '0;
      busy   <= '0;
      gnt_q  <= '0;
      cnt    <= '0;
      FD_OUT <= '0;
      SLWR   <= STROBE_OFF;
      PKTEND <= STROBE_OFF;
    end else begin
      state  <= state_nx;
      SLWR   <= wr_en ? STROBE_ON : STROBE_OFF;
      PKTEND <= pkt_fire ? STROBE_ON : STROBE_OFF;
      if (wr_en) begin
        FD_OUT <= wr_word;
        cnt    <= cnt + CW'(1);
      end
      if (state == S_COMMIT) cnt <= '0;
      if (state == S_IDLE && gany) begin
        busy  <= gidx;
        gnt_q <= gnt;
        ptr   <= (gidx == 4'(NUM_CH - 1)) ? 4'd0 : gidx + 4'd1;
      end
    end
  end

  assign FD_OE     = (state == S_HDR) || (state == S_DATA) || (state == S_COMMIT);
  assign GRANT_ACT = FD_OE;
  assign BUSY_CH   = busy;
  assign SLOE      = 1'b1;
  assign SLRD      = 1'b1;
  assign FIFOADR   = EP_ADDR;

endmodule

// File: tb/tb_slave_fifo_mux_writer.sv
// Directed bench for slave_fifo_mux_writer: per-channel source queues,
// an FD-bus monitor, and hand-computed expected write sequences.
module tb_slave_fifo_mux_writer;

  localparam int NCH = 4;

  logic             CLK = 1'b0;
  logic             RST = 1'b1;
  logic [NCH-1:0]   CH_VALID;
  logic [16*NCH-1:0] CH_DATA;
  logic [NCH-1:0]   CH_LAST;
  logic [NCH-1:0]   CH_READY;
  logic             FLAG_FULL = 1'b1;
  logic [15:0]      FD_OUT;
  logic             FD_OE;
  logic             SLWR;
  logic             PKTEND;
  logic             SLOE;
  logic             SLRD;
  logic [1:0]       FIFOADR;
  logic [3:0]       BUSY_CH;
  logic             GRANT_ACT;

  slave_fifo_mux_writer #(
    .NUM_CH(NCH),
    .PKT_WORDS(256),
    .EP_ADDR(2'b10),
    .HDR_TAG(8'hA5)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .CH_VALID(CH_VALID),
    .CH_DATA(CH_DATA),
    .CH_LAST(CH_LAST),
    .CH_READY(CH_READY),
    .FLAG_FULL(FLAG_FULL),
    .FD_OUT(FD_OUT),
    .FD_OE(FD_OE),
    .SLWR(SLWR),
    .PKTEND(PKTEND),
    .SLOE(SLOE),
    .SLRD(SLRD),
    .FIFOADR(FIFOADR),
    .BUSY_CH(BUSY_CH),
    .GRANT_ACT(GRANT_ACT)
  );

  always #5 CLK = ~CLK;

  int n_chk = 0;
  int n_bad = 0;

  logic [16:0] src_q [NCH][$];
  logic [15:0] wr_q [$];
  logic [15:0] exp_q [$];
  logic [3:0]  busy_q [$];
  int          pk_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic push(input int ch, input logic [15:0] d, input logic last);
    src_q[ch].push_back({last, d});
  endtask

  function automatic bit srcs_empty();
    bit e = 1'b1;
    for (int i = 0; i < NCH; i++) if (src_q[i].size() != 0) e = 1'b0;
    return e;
  endfunction

  // source driver: pop on a sampled handshake, present next word
  initial begin
    logic [NCH-1:0] fire;
    CH_VALID = '0;
    CH_DATA = '0;
    CH_LAST = '0;
    forever begin
      @(negedge CLK);
      fire = CH_VALID & CH_READY;
      @(posedge CLK);
      #1;
      for (int i = 0; i < NCH; i++) begin
        if (RST) src_q[i].delete();
        else if (fire[i]) void'(src_q[i].pop_front());
        if (src_q[i].size() > 0) begin
          CH_VALID[i] = 1'b1;
          CH_DATA[16*i +: 16] = src_q[i][0][15:0];
          CH_LAST[i] = src_q[i][0][16];
        end else begin
          CH_VALID[i] = 1'b0;
          CH_LAST[i] = 1'b0;
        end
      end
    end
  end

  // FD bus monitor
  initial begin
    logic prev_slwr = 1'b1;
    logic prev_ga = 1'b0;
    int low_cnt = 100;
    forever begin
      @(negedge CLK);
      if (SLWR === 1'b0) wr_q.push_back(FD_OUT);
      if (PKTEND === 1'b0) begin
        pk_cnt++;
        chk("pkt_after_wr", {30'd0, SLWR, prev_slwr}, 32'd2);
      end
      if (GRANT_ACT === 1'b1 && !prev_ga) begin
        busy_q.push_back(BUSY_CH);
        chk("gap_before_grant", 32'(low_cnt >= 1), 32'd1);
      end
      if (GRANT_ACT === 1'b1) low_cnt = 0;
      else low_cnt++;
      prev_slwr = SLWR;
      prev_ga = (GRANT_ACT === 1'b1);
    end
  end

  task automatic run(input int budget);
    int idle = 0;
    int n = 0;
    while (idle < 3 && n < budget) begin
      @(negedge CLK);
      n++;
      if (srcs_empty() && CH_VALID == '0 && !GRANT_ACT) idle++;
      else idle = 0;
    end
    chk("run_done", 32'(idle >= 3), 32'd1);
  endtask

  task automatic wait_wr(input int n, input int budget);
    int k = 0;
    while (wr_q.size() < n && k < budget) begin
      @(negedge CLK);
      k++;
    end
    chk("wait_wr", 32'(wr_q.size() >= n), 32'd1);
  endtask

  task automatic cmp_wr(input string tag);
    chk({tag, "_len"}, wr_q.size(), exp_q.size());
    for (int j = 0; j < exp_q.size() && j < wr_q.size(); j++)
      chk(tag, {16'(j), wr_q[j]}, {16'(j), exp_q[j]});
  endtask

  task automatic clr();
    wr_q.delete();
    exp_q.delete();
    busy_q.delete();
    pk_cnt = 0;
  endtask

  initial begin
    repeat (3) @(posedge CLK);
    #2 RST = 1'b0;
    @(negedge CLK);
    chk("rst_slwr", SLWR, 1);
    chk("rst_pktend", PKTEND, 1);
    chk("rst_oe", FD_OE, 0);
    chk("rst_fd", FD_OUT, 0);
    chk("rst_ready", CH_READY, 0);
    chk("rst_busy", BUSY_CH, 0);
    chk("rst_gact", GRANT_ACT, 0);
    chk("rst_sloe_slrd", {SLOE, SLRD}, 2'b11);
    chk("rst_fifoadr", FIFOADR, 2'b10);

    // ch2, three words
    clr();
    push(2, 16'h1111, 0);
    push(2, 16'h2222, 0);
    push(2, 16'h3333, 1);
    run(100);
    exp_q = '{16'hA502, 16'h1111, 16'h2222, 16'h3333};
    cmp_wr("t1_wr");
    chk("t1_pkt", pk_cnt, 1);

    // ch3, 256 payload words: 257 writes crosses one auto-commit
    clr();
    exp_q.push_back(16'hA503);
    for (int k = 0; k < 256; k++) begin
      push(3, 16'(16'h6000 + k), k == 255);
      exp_q.push_back(16'(16'h6000 + k));
    end
    run(800);
    cmp_wr("t2a_wr");
    chk("t2a_pkt", pk_cnt, 1);

    // ch0, 255 payload words: exactly one full packet, no PKTEND
    clr();
    exp_q.push_back(16'hA500);
    for (int k = 0; k < 255; k++) begin
      push(0, 16'(16'h7000 + k), k == 254);
      exp_q.push_back(16'(16'h7000 + k));
    end
    run(800);
    cmp_wr("t2b_wr");
    chk("t2b_pkt", pk_cnt, 0);
    chk("t2b_gact", GRANT_ACT, 0);

    // ch0/1/3 together, pointer at 1
    clr();
    for (int k = 0; k < 2; k++) begin
      push(0, 16'(16'h3000 + k), k == 1);
      push(1, 16'(16'h3010 + k), k == 1);
      push(3, 16'(16'h3030 + k), k == 1);
    end
    run(200);
    exp_q = '{16'hA501, 16'h3010, 16'h3011,
              16'hA503, 16'h3030, 16'h3031,
              16'hA500, 16'h3000, 16'h3001};
    cmp_wr("t3_wr");
    chk("t3_pkt", pk_cnt, 3);
    chk("t3_ngrant", busy_q.size(), 3);
    if (busy_q.size() == 3)
      chk("t3_busy", {busy_q[0], busy_q[1], busy_q[2]}, 12'h130);

    // FLAG_FULL low for 5 cycles mid-DATA on ch1
    clr();
    exp_q.push_back(16'hA501);
    for (int k = 0; k < 6; k++) begin
      push(1, 16'(16'h4000 + k), k == 5);
      exp_q.push_back(16'(16'h4000 + k));
    end
    wait_wr(3, 50);
    @(posedge CLK);
    #1 FLAG_FULL = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge CLK);
      chk("t4_ready_stall", CH_READY, 0);
      if (k > 0) chk("t4_slwr_stall", SLWR, 1);
    end
    @(posedge CLK);
    #1 FLAG_FULL = 1'b1;
    run(200);
    cmp_wr("t4_wr");
    chk("t4_pkt", pk_cnt, 1);

    // reset during ch1 DATA
    clr();
    for (int k = 0; k < 10; k++) push(1, 16'(16'h5000 + k), k == 9);
    wait_wr(3, 50);
    @(posedge CLK);
    #2 RST = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    chk("t5_slwr", SLWR, 1);
    chk("t5_pktend", PKTEND, 1);
    chk("t5_oe", FD_OE, 0);
    chk("t5_fd", FD_OUT, 0);
    chk("t5_busy", BUSY_CH, 0);
    chk("t5_gact", GRANT_ACT, 0);
    chk("t5_ready", CH_READY, 0);
    @(posedge CLK);
    #2 RST = 1'b0;
    repeat (3) @(negedge CLK);
    chk("t5_nopkt", pk_cnt, 0);
    clr();
    push(1, 16'h5A5A, 0);
    push(1, 16'hC3C3, 1);
    run(100);
    exp_q = '{16'hA501, 16'h5A5A, 16'hC3C3};
    cmp_wr("t5_wr");
    chk("t5_pkt", pk_cnt, 1);

    // single-word message on ch3
    clr();
    push(3, 16'hBEEF, 1);
    run(100);
    exp_q = '{16'hA503, 16'hBEEF};
    cmp_wr("t6_wr");
    chk("t6_pkt", pk_cnt, 1);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
